vrgather_seq: RTL and testbench

- Sequencer that drives the combinational LMUL=4 vrgather datapath (vs2/vs1/vd buses of 4×VLEN bits).
- Accepts one vrgather.vv command at a time and reads the 4-register vs2 and vs1 groups from the vector register file, one register per cycle.
- Presents the assembled buses plus SEW to the gather unit, captures the result, then writes the 4-register vd group back one register per cycle.
- Sits between the vector issue stage and the shared register-file port.

---
 rtl/vrgather_seq_pkg.sv | 33 +++
 rtl/vrgather_seq.sv | 182 ++++++++++++++++++
 tb/tb_vrgather_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrgather_seq_pkg.sv
// Shared definitions for the vrgather sequencer: FSM encoding, group size,
// SEW codes, register-address width and the command legality rule.
package vrgather_seq_pkg;

  localparam int NREG   = 4;
  localparam int ADDR_W = 5;

  localparam logic SEW8  = 1'b0;
  localparam logic SEW32 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  typedef logic [ADDR_W-1:0] vreg_t;

  // A command is legal when every group base is 4-aligned and the destination
  // group does not coincide with either source group. Alignment also guarantees
  // that base+offset never wraps inside the 5-bit address space.
  function automatic logic cmd_legal(input vreg_t vd, input vreg_t vs1, input vreg_t vs2);
    logic aligned;
    logic overlap;
    aligned = (vd[1:0] == 2'b00) && (vs1[1:0] == 2'b00) && (vs2[1:0] == 2'b00);
    overlap = (vd[4:2] == vs1[4:2]) || (vd[4:2] == vs2[4:2]);
    return aligned && !overlap;
  endfunction

endpackage

// File: rtl/vrgather_seq.sv
// Sequencer for the LMUL=4 vrgather datapath: reads the vs2/vs1 groups one
// register per cycle, presents them to the combinational gather unit, captures
// the result and writes the vd group back one register per cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a command; cmd_ready high
//   READ  | 8 reads (vs2 group then vs1 group), data lands one cycle later
//   DRAIN | last read data (vs1 register 3) arrives; gather buses loaded
//   EXEC  | gather buses stable; result captured at the end of the cycle
//   WRITE | 4 writes of the result group to vd; done on the last one
//   ERR   | rejected command; err pulse, no register-file traffic
module vrgather_seq
  import vrgather_seq_pkg::*;
#(
  parameter int VLEN_BITS = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_sew,
  input  logic [ADDR_W-1:0]         cmd_vd,
  input  logic [ADDR_W-1:0]         cmd_vs1,
  input  logic [ADDR_W-1:0]         cmd_vs2,
  output logic                      rf_rd_en,
  output logic [ADDR_W-1:0]         rf_rd_addr,
  input  logic [VLEN_BITS-1:0]      rf_rd_data,
  output logic                      rf_wr_en,
  output logic [ADDR_W-1:0]         rf_wr_addr,
  output logic [VLEN_BITS-1:0]      rf_wr_data,
  output logic                      g_sew,
  output logic [VLEN_BITS*NREG-1:0] g_vs2_bus,
  output logic [VLEN_BITS*NREG-1:0] g_vs1_bus,
  input  logic [VLEN_BITS*NREG-1:0] g_vd_bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;

  logic  lat_sew;
  vreg_t lat_vd, lat_vs1, lat_vs2;

  // Slots 0..3 hold the vs2 group, 4..6 the first three vs1 registers.
  // The fourth vs1 register arrives in DRAIN and goes straight onto g_vs1_bus.
  logic [2*NREG-2:0][VLEN_BITS-1:0] cap_q;
  logic [NREG-1:0][VLEN_BITS-1:0]   res_q;

  logic handshake;
  assign handshake = cmd_valid && cmd_ready;

  // State and sequencing counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Command fields are latched on the handshake and held for the whole command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_sew <= SEW8;
      lat_vd  <= '0;
      lat_vs1 <= '0;
      lat_vs2 <= '0;
    end else if (handshake) begin
      lat_sew <= cmd_sew;
      lat_vd  <= cmd_vd;
      lat_vs1 <= cmd_vs1;
      lat_vs2 <= cmd_vs2;
    end
  end

  // Read data returned during READ belongs to the previous counter value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
    end else if (state == ST_READ && cnt != 3'd0) begin
      cap_q[cnt - 3'd1] <= rf_rd_data;
    end
  end

  // Gather-unit inputs only change at the DRAIN->EXEC edge, so they are stable
  // through EXEC and keep their last values afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_sew     <= SEW8;
      g_vs2_bus <= '0;
      g_vs1_bus <= '0;
    end else if (state == ST_DRAIN) begin
      g_sew     <= lat_sew;
      g_vs2_bus <= cap_q[NREG-1:0];
      g_vs1_bus <= {rf_rd_data, cap_q[2*NREG-2:NREG]};
    end
  end

  // Gather result captured at the end of EXEC for the write-back phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else if (state == ST_EXEC) begin
      res_q <= g_vd_bus;
    end
  end

  // Next-state logic and register-file / status outputs.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        // Checking the bus fields here is equivalent to checking the values
        // being latched on this same edge.
        if (handshake) begin
          cnt_nx   = '0;
          state_nx = cmd_legal(cmd_vd, cmd_vs1, cmd_vs2) ? ST_READ : ST_ERR;
        end
      end

      ST_READ: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = cnt[2] ? (lat_vs1 + {3'b000, cnt[1:0]})
                            : (lat_vs2 + {3'b000, cnt[1:0]});
        cnt_nx     = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nx = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        state_nx = ST_EXEC;
      end

      ST_EXEC: begin
        cnt_nx   = '0;
        state_nx = ST_WRITE;
      end

      ST_WRITE: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = lat_vd + {3'b000, cnt[1:0]};
        rf_wr_data = res_q[cnt[1:0]];
        if (cnt == 3'd3) begin
          done     = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end

      ST_ERR: begin
        err      = 1'b1;
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vrgather_seq.sv
// Bench for vrgather_seq: wraps the sequencer with a register-file model and a
// gather-unit model, checks cycle-accurate strobes against the documented
// latency and the final register file against an element-level reference.
module tb_vrgather_seq;
  import vrgather_seq_pkg::*;

  localparam int VL = 128;
  localparam int BW = VL * NREG;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_sew;
  logic [4:0]    cmd_vd, cmd_vs1, cmd_vs2;
  logic          rf_rd_en, rf_wr_en;
  logic [4:0]    rf_rd_addr, rf_wr_addr;
  logic [VL-1:0] rf_rd_data, rf_wr_data;
  logic          g_sew;
  logic [BW-1:0] g_vs2_bus, g_vs1_bus, g_vd_bus;
  logic          busy, done, err;

  vrgather_seq #(.VLEN_BITS(VL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sew(cmd_sew),
    .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .g_sew(g_sew), .g_vs2_bus(g_vs2_bus), .g_vs1_bus(g_vs1_bus), .g_vd_bus(g_vd_bus),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic sew; logic [4:0] vd; logic [4:0] vs1; logic [4:0] vs2; } cmd_t;
  typedef struct packed { logic sew; logic [4:0] vd; logic [4:0] vs1; logic [4:0] vs2; logic exp_err; } vec_t;

  // Register file: 32 entries, one-cycle read latency, plus a bench load port.
  logic [VL-1:0] rf [32];
  logic          ld_en = 1'b0;
  logic [4:0]    ld_addr = '0;
  logic [VL-1:0] ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_data;
    else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    rf_rd_data <= rf_rd_en ? rf[rf_rd_addr] : '0;
  end

  // Gather unit: out-of-range indices produce zero.
  logic [5:0] gb;
  logic [3:0] gw;
  always_comb begin
    g_vd_bus = '0;
    gb = '0;
    gw = '0;
    if (g_sew == SEW8) begin
      for (int i = 0; i < 64; i++) begin
        gb = g_vs1_bus[i*8 +: 6];
        if (g_vs1_bus[i*8 +: 8] < 8'd64) g_vd_bus[i*8 +: 8] = g_vs2_bus[32'(gb)*8 +: 8];
      end
    end else begin
      for (int j = 0; j < 16; j++) begin
        gw = g_vs1_bus[j*32 +: 4];
        if (g_vs1_bus[j*32 +: 32] < 32'd16) g_vd_bus[j*32 +: 32] = g_vs2_bus[32'(gw)*32 +: 32];
      end
    end
  end

  // Protocol monitor: strobe exclusivity, busy/ready coherence, pulse counts.
  int mon_bad = 0, mon_done = 0, mon_err = 0;
  always @(negedge clk) begin
    if (rf_rd_en && rf_wr_en) mon_bad++;
    if (busy == cmd_ready) mon_bad++;
    if (done) mon_done++;
    if (err) mon_err++;
  end

  int checks = 0, errors = 0, exp_done = 0, exp_err = 0;
  logic [VL-1:0] rf_ref [32];
  logic [VL-1:0] ref_res [4];
  logic rec_rd [32], rec_wr [32], rec_done [32], rec_err [32], rec_rdy [32];
  logic [4:0] rec_ra [32], rec_wa [32];
  vec_t tbl [9];

  task automatic chk(input string name, input logic [VL-1:0] act, input logic [VL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic legal(input cmd_t c);
    return (c.vd % 4 == 0) && (c.vs1 % 4 == 0) && (c.vs2 % 4 == 0) &&
           (c.vd / 4 != c.vs1 / 4) && (c.vd / 4 != c.vs2 / 4);
  endfunction

  task automatic load_reg(input logic [4:0] a, input logic [VL-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    rf_ref[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Reference: vrgather on flat element arrays of the two source groups.
  task automatic ref_exec(input cmd_t c);
    logic [7:0]  sb [64];
    logic [7:0]  ib [64];
    logic [31:0] sw [16];
    logic [31:0] iw [16];
    logic [4:0]  r2, r1;
    for (int i = 0; i < 64; i++) begin
      r2 = c.vs2 + 5'(i / 16);
      r1 = c.vs1 + 5'(i / 16);
      sb[i] = rf_ref[r2][(i % 16)*8 +: 8];
      ib[i] = rf_ref[r1][(i % 16)*8 +: 8];
    end
    for (int j = 0; j < 16; j++) begin
      r2 = c.vs2 + 5'(j / 4);
      r1 = c.vs1 + 5'(j / 4);
      sw[j] = rf_ref[r2][(j % 4)*32 +: 32];
      iw[j] = rf_ref[r1][(j % 4)*32 +: 32];
    end
    for (int k = 0; k < 4; k++) ref_res[k] = '0;
    if (c.sew == SEW8) begin
      for (int i = 0; i < 64; i++)
        ref_res[i / 16][(i % 16)*8 +: 8] = (ib[i] < 8'd64) ? sb[ib[i][5:0]] : 8'h00;
    end else begin
      for (int j = 0; j < 16; j++)
        ref_res[j / 4][(j % 4)*32 +: 32] = (iw[j] < 32'd16) ? sw[iw[j][3:0]] : 32'h0;
    end
  endtask

  task automatic ref_commit(input cmd_t c, input logic lg);
    if (lg) begin
      ref_exec(c);
      for (int k = 0; k < 4; k++) rf_ref[c.vd + 5'(k)] = ref_res[k];
      exp_done++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_rf(input string tag);
    int nb;
    int first;
    nb = 0;
    first = 0;
    for (int r = 0; r < 32; r++) begin
      if (rf[r] !== rf_ref[r]) begin
        if (nb == 0) first = r;
        nb++;
      end
    end
    checks++;
    if (nb != 0) begin
      errors++;
      $display("FAIL %s regfile: %0d regs differ, v%0d got %0h expected %0h",
               tag, nb, first, rf[first], rf_ref[first]);
    end
  endtask

  // Drives the command and returns at the falling edge of the handshake cycle.
  task automatic start_cmd(input cmd_t c);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_sew = c.sew; cmd_vd = c.vd; cmd_vs1 = c.vs1; cmd_vs2 = c.vs2;
    t = 0;
    while (!cmd_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1 within 40 cycles");
    end
  endtask

  task automatic record(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      rec_rd[k] = rf_rd_en;  rec_ra[k] = rf_rd_addr;
      rec_wr[k] = rf_wr_en;  rec_wa[k] = rf_wr_addr;
      rec_done[k] = done;    rec_err[k] = err;
      rec_rdy[k] = cmd_ready;
    end
  endtask

  // Expected strobes relative to the handshake cycle: reads 1-8, writes 11-14,
  // done 14, ready 15; a rejected command pulses err in 1 and is ready in 2.
  task automatic check_trace(input cmd_t c, input logic lg, input int base, input string tag);
    int nbad [5];
    int frel [5];
    logic [5:0] fa [5];
    logic [5:0] fe [5];
    logic [5:0] a [5];
    logic [5:0] e [5];
    int k;
    string nm;
    for (int n = 0; n < 5; n++) begin nbad[n] = 0; frel[n] = 0; fa[n] = '0; fe[n] = '0; end
    for (int rel = 1; rel <= 15; rel++) begin
      k = base + rel;
      e[0] = (lg && rel <= 8) ? {1'b1, (rel <= 4) ? c.vs2 + 5'(rel - 1) : c.vs1 + 5'(rel - 5)} : 6'd0;
      a[0] = rec_rd[k] ? {1'b1, rec_ra[k]} : 6'd0;
      e[1] = (lg && rel >= 11 && rel <= 14) ? {1'b1, c.vd + 5'(rel - 11)} : 6'd0;
      a[1] = rec_wr[k] ? {1'b1, rec_wa[k]} : 6'd0;
      e[2] = {5'd0, lg && rel == 14};
      a[2] = {5'd0, rec_done[k]};
      e[3] = {5'd0, !lg && rel == 1};
      a[3] = {5'd0, rec_err[k]};
      e[4] = {5'd0, lg ? (rel >= 15) : (rel >= 2)};
      a[4] = {5'd0, rec_rdy[k]};
      for (int n = 0; n < 5; n++) begin
        if (a[n] !== e[n]) begin
          if (nbad[n] == 0) begin frel[n] = rel; fa[n] = a[n]; fe[n] = e[n]; end
          nbad[n]++;
        end
      end
    end
    for (int n = 0; n < 5; n++) begin
      case (n)
        0: nm = "rd";
        1: nm = "wr";
        2: nm = "done";
        3: nm = "err";
        default: nm = "ready";
      endcase
      checks++;
      if (nbad[n] != 0) begin
        errors++;
        $display("FAIL %s %s_trace: %0d bad cycles, first at cycle %0d got %0h expected %0h",
                 tag, nm, nbad[n], frel[n], fa[n], fe[n]);
      end
    end
  endtask

  task automatic run_cmd(input cmd_t c, input logic lg, input string tag);
    start_cmd(c);
    record(1, 1);
    cmd_valid = 1'b0;
    record(2, 15);
    check_trace(c, lg, 0, tag);
    ref_commit(c, lg);
    check_rf(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c, c2;
    logic [VL-1:0] tmp;

    tbl[0] = '{1'b0, 5'd12, 5'd4,  5'd8,  1'b0};
    tbl[1] = '{1'b0, 5'd5,  5'd4,  5'd8,  1'b1};
    tbl[2] = '{1'b0, 5'd8,  5'd4,  5'd8,  1'b1};
    tbl[3] = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b1};
    tbl[4] = '{1'b1, 5'd0,  5'd4,  5'd8,  1'b0};
    tbl[5] = '{1'b0, 5'd4,  5'd6,  5'd8,  1'b1};
    tbl[6] = '{1'b1, 5'd4,  5'd8,  5'd9,  1'b1};
    tbl[7] = '{1'b0, 5'd28, 5'd0,  5'd0,  1'b0};
    tbl[8] = '{1'b1, 5'd30, 5'd0,  5'd4,  1'b1};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_sew = 1'b0; cmd_vd = '0; cmd_vs1 = '0; cmd_vs2 = '0;
    for (int r = 0; r < 32; r++) load_reg(5'(r), {$urandom, $urandom, $urandom, $urandom});

    @(negedge clk);
    chk("reset_ctrl", 128'({cmd_ready, busy, rf_rd_en, rf_wr_en, done, err, g_sew}), 128'(7'b1000000));
    chk("reset_gbus", 128'(|{g_vs2_bus, g_vs1_bus}), 128'(0));
    rst = 1'b0;

    // Identity gather, int8.
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 16; b++) tmp[b*8 +: 8] = 8'(8'hA0 + r*16 + b);
      load_reg(5'(8 + r), tmp);
      for (int b = 0; b < 16; b++) tmp[b*8 +: 8] = 8'(r*16 + b);
      load_reg(5'(4 + r), tmp);
    end
    c = '{SEW8, 5'd12, 5'd4, 5'd8};
    run_cmd(c, 1'b1, "identity");
    chk("identity_v12", rf[12], rf[8]);
    for (int k = 0; k < 4; k++) chk($sformatf("gbus_hold_vs2_%0d", k), g_vs2_bus[k*VL +: VL], rf_ref[8 + k]);

    // Reverse with one out-of-range index.
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 16; b++) tmp[b*8 +: 8] = 8'(63 - (r*16 + b));
      if (r == 0) tmp[47:40] = 8'd200;
      load_reg(5'(4 + r), tmp);
    end
    run_cmd(c, 1'b1, "reverse");
    chk("reverse_byte0", 128'(rf[12][7:0]), 128'(8'hDF));
    chk("reverse_byte5", 128'(rf[12][47:40]), 128'(8'h00));
    chk("reverse_byte63", 128'(rf[15][127:120]), 128'(8'hA0));

    // int32 broadcast of vs2 word 3, word index 16 yields zero.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 4; w++) tmp[w*32 +: 32] = 32'd3;
      if (r == 1) tmp[127:96] = 32'd16;
      load_reg(5'(4 + r), tmp);
    end
    load_reg(5'd8, {32'hDEADBEEF, $urandom, $urandom, $urandom});
    c = '{SEW32, 5'd16, 5'd4, 5'd8};
    run_cmd(c, 1'b1, "broadcast");
    chk("bcast_word0", 128'(rf[16][31:0]), 128'(32'hDEADBEEF));
    chk("bcast_word7", 128'(rf[17][127:96]), 128'(32'h0));
    chk("bcast_word15", 128'(rf[19][127:96]), 128'(32'hDEADBEEF));

    // Legality table.
    for (int t = 0; t < 9; t++) begin
      c = '{tbl[t].sew, tbl[t].vd, tbl[t].vs1, tbl[t].vs2};
      run_cmd(c, !tbl[t].exp_err, $sformatf("table%0d", t));
    end

    // Back-to-back: cmd_valid held across two commands.
    c  = '{SEW8,  5'd12, 5'd4, 5'd8};
    c2 = '{SEW32, 5'd20, 5'd4, 5'd8};
    start_cmd(c);
    record(1, 1);
    cmd_sew = c2.sew; cmd_vd = c2.vd; cmd_vs1 = c2.vs1; cmd_vs2 = c2.vs2;
    record(2, 16);
    cmd_valid = 1'b0;
    record(17, 30);
    check_trace(c, 1'b1, 0, "b2b_first");
    check_trace(c2, 1'b1, 15, "b2b_second");
    ref_commit(c, 1'b1);
    ref_commit(c2, 1'b1);
    check_rf("b2b");

    // Reset during the second write cycle.
    c = '{SEW8, 5'd24, 5'd4, 5'd8};
    start_cmd(c);
    record(1, 1);
    cmd_valid = 1'b0;
    record(2, 12);
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", 128'({rf_wr_en, rf_rd_en}), 128'(2'b00));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready_busy", 128'({cmd_ready, busy}), 128'(2'b10));
    ref_exec(c);
    rf_ref[24] = ref_res[0];
    check_rf("rst_mid");
    c = '{SEW32, 5'd24, 5'd4, 5'd8};
    run_cmd(c, 1'b1, "after_reset");

    // Randomized commands against the reference model.
    for (int n = 0; n < 12; n++) begin
      c.sew = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        c.vd  = 5'(4 * $urandom_range(0, 7));
        c.vs1 = 5'(4 * $urandom_range(0, 7));
        c.vs2 = 5'(4 * $urandom_range(0, 7));
      end else begin
        c.vd = 5'($urandom); c.vs1 = 5'($urandom); c.vs2 = 5'($urandom);
      end
      if (c.vs1[1:0] == 2'b00) begin
        for (int r = 0; r < 4; r++) begin
          for (int b = 0; b < 16; b++) tmp[b*8 +: 8] = 8'($urandom_range(0, 70));
          if (c.sew == SEW32)
            for (int w = 0; w < 4; w++) tmp[w*32 +: 32] = 32'($urandom_range(0, 18));
          load_reg(c.vs1 + 5'(r), tmp);
        end
      end
      run_cmd(c, legal(c), $sformatf("rand%0d", n));
    end

    @(negedge clk);
    chk("monitor_protocol", 128'(mon_bad), 128'(0));
    chk("done_pulses", 128'(mon_done), 128'(exp_done));
    chk("err_pulses", 128'(mon_err), 128'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
